// File: rtl/sr_pkg.sv
// Shared opcode and FSM state definitions for the SR flag arbiter slice.
package sr_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_TGL = 2'b11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/sr_cell.sv
// Single SR flag flip-flop; the arbiter guarantees s and r are never both high.
module sr_cell (
  input  logic s,
  input  logic r,
  input  logic clk,
  input  logic rst,
  output logic q
);

  logic q_r;

  // Flag storage: set dominates the encoding only nominally, since s=r=1 never arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= 1'b0;
    end else if (s) begin
      q_r <= 1'b1;
    end else if (r) begin
      q_r <= 1'b0;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/sr_flag_arbiter_chk.sv
// Invariant checker for the S/R pulse vectors driven into the flag bank.
module sr_flag_arbiter_chk #(
  parameter int NFLAGS = 6
) (
  input logic              clk,
  input logic              rst,
  input logic              busy,
  input logic [NFLAGS-1:0] s_vec,
  input logic [NFLAGS-1:0] r_vec
);

  a_no_sr_overlap: assert property (@(posedge clk) disable iff (rst) (s_vec & r_vec) == '0)
    else $error("s_vec and r_vec overlap");

  a_one_pulse: assert property (@(posedge clk) disable iff (rst) $countones(s_vec | r_vec) <= 1)
    else $error("more than one S/R pulse");

  a_quiet_idle: assert property (@(posedge clk) disable iff (rst) !busy |-> (s_vec | r_vec) == '0)
    else $error("S/R pulse outside DRIVE");

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin command front-end: serialises set/clear/toggle commands from
// several requesters into one-cycle S/R pulses for a bank of sr_cell flags.
module sr_flag_arbiter #(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 6,
  parameter int IDXW   = 3,
  parameter int RIDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [IDXW*NREQ-1:0] req_idx,
  output logic [NREQ-1:0]      req_ready,
  output logic [NFLAGS-1:0]    flags,
  output logic [NFLAGS-1:0]    s_vec,
  output logic [NFLAGS-1:0]    r_vec,
  output logic                 busy,
  output logic [RIDW-1:0]      grant_id,
  output logic                 idx_err
);

  import sr_pkg::*;

  state_t              state_r;
  logic [RIDW-1:0]     rr_ptr_r;
  logic [RIDW-1:0]     grant_id_r;
  logic                busy_r;
  logic                idx_err_r;
  logic [NFLAGS-1:0]   s_vec_r;
  logic [NFLAGS-1:0]   r_vec_r;
  logic [NFLAGS-1:0]   flags_s;

  logic [RIDW:0]       pick_s;
  logic                pick_found_s;
  logic [RIDW-1:0]     pick_id_s;
  logic [1:0]          pick_op_s;
  logic [IDXW-1:0]     pick_idx_s;
  logic [NFLAGS-1:0]   set_s;
  logic [NFLAGS-1:0]   clr_s;
  logic                idx_bad_s;

  // Returns {found, id}: first valid requester at or after ptr, with wrap-around.
  function automatic logic [RIDW:0] rr_pick(input logic [NREQ-1:0] v, input logic [RIDW-1:0] ptr);
    logic [RIDW:0] res;
    int            c;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = (int'(ptr) + k) % NREQ;
      if (v[c]) begin
        res = {1'b1, RIDW'(c)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [RIDW-1:0] next_ptr(input logic [RIDW-1:0] id);
    return (id == RIDW'(NREQ - 1)) ? RIDW'(0) : id + RIDW'(1);
  endfunction

  // Arbitration winner and its command fields.
  always_comb begin
    pick_s       = rr_pick(req_valid, rr_ptr_r);
    pick_found_s = pick_s[RIDW];
    pick_id_s    = pick_s[RIDW-1:0];
    pick_op_s    = req_op[{pick_id_s, 1'b0} +: 2];
    pick_idx_s   = req_idx[int'(pick_id_s) * IDXW +: IDXW];
  end

  // Ready is only offered in IDLE and is forced low while reset is held.
  always_comb begin
    req_ready = '0;
    if (!rst && state_r == IDLE && pick_found_s) begin
      req_ready[pick_id_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Decode the winning command against the current flags into a one-hot S or R.
  // Flags cannot change during IDLE, so resolving a toggle here matches DRIVE.
  always_comb begin
    set_s     = '0;
    clr_s     = '0;
    idx_bad_s = ({1'b0, pick_idx_s} >= (IDXW + 1)'(NFLAGS));
    for (int f = 0; f < NFLAGS; f++) begin
      case ({pick_idx_s == IDXW'(f), pick_op_s})
        {1'b1, OP_SET}: set_s[f] = 1'b1;
        {1'b1, OP_CLR}: clr_s[f] = 1'b1;
        {1'b1, OP_TGL}: begin
          set_s[f] = ~flags_s[f];
          clr_s[f] = flags_s[f];
        end
        default: begin
          set_s[f] = 1'b0;
          clr_s[f] = 1'b0;
        end
      endcase
    end
  end

  // Two-state controller; all outputs are registered on the handshake edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      grant_id_r <= '0;
      busy_r     <= 1'b0;
      idx_err_r  <= 1'b0;
      s_vec_r    <= '0;
      r_vec_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            state_r    <= DRIVE;
            rr_ptr_r   <= next_ptr(pick_id_s);
            grant_id_r <= pick_id_s;
            busy_r     <= 1'b1;
            idx_err_r  <= idx_bad_s;
            s_vec_r    <= set_s;
            r_vec_r    <= clr_s;
          end else begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            idx_err_r  <= 1'b0;
            s_vec_r    <= '0;
            r_vec_r    <= '0;
          end
        end
        DRIVE: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          idx_err_r <= 1'b0;
          s_vec_r   <= '0;
          r_vec_r   <= '0;
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          idx_err_r <= 1'b0;
          s_vec_r   <= '0;
          r_vec_r   <= '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NFLAGS; g++) begin : g_cell
    sr_cell u_cell (
      .s   (s_vec_r[g]),
      .r   (r_vec_r[g]),
      .clk (clk),
      .rst (rst),
      .q   (flags_s[g])
    );
  end

  sr_flag_arbiter_chk #(.NFLAGS(NFLAGS)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .busy  (busy_r),
    .s_vec (s_vec_r),
    .r_vec (r_vec_r)
  );

  assign flags    = flags_s;
  assign s_vec    = s_vec_r;
  assign r_vec    = r_vec_r;
  assign busy     = busy_r;
  assign grant_id = grant_id_r;
  assign idx_err  = idx_err_r;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Self-checking bench for sr_flag_arbiter: directed scenarios plus randomized
// traffic checked against a behavioural model of the flag bank and arbiter.
module tb_sr_flag_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = 4'b0000;
  logic [7:0]  req_op = 8'h00;
  logic [11:0] req_idx = 12'h000;
  logic [3:0]  req_ready;
  logic [5:0]  flags, s_vec, r_vec;
  logic        busy, idx_err;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;

  // Behavioural model: flag contents, fairness pointer, and the command in service.
  logic [5:0] m_flags;
  int         m_ptr;
  bit         m_drive;
  int         m_gid, m_op, m_idx;
  logic [3:0] just_gr;

  sr_flag_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
    .req_ready(req_ready), .flags(flags), .s_vec(s_vec), .r_vec(r_vec),
    .busy(busy), .grant_id(grant_id), .idx_err(idx_err)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [2:0] idx);
    req_valid[i]       = v;
    req_op[2*i +: 2]   = op;
    req_idx[3*i +: 3]  = idx;
  endtask

  task automatic model_reset();
    m_flags = 6'b000000; m_ptr = 0; m_drive = 0; m_gid = 0; m_op = 0; m_idx = 0;
    just_gr = 4'b0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'b0000;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Advance one clock: update the model from the inputs presented this cycle.
  task automatic tick();
    int w;
    w = -1;
    just_gr = 4'b0000;
    if (rst) begin
      model_reset();
    end else if (m_drive) begin
      if (m_idx < 6) begin
        case (m_op)
          1: m_flags[m_idx] = 1'b0;
          2: m_flags[m_idx] = 1'b1;
          3: m_flags[m_idx] = ~m_flags[m_idx];
          default: ;
        endcase
      end
      m_drive = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (req_valid[c] && w < 0) w = c;
      end
      if (w >= 0) begin
        m_drive = 1; m_gid = w;
        m_op = int'(req_op[2*w +: 2]);
        m_idx = int'(req_idx[3*w +: 3]);
        m_ptr = (w + 1) % 4;
        just_gr[w] = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'b10, 3'(i));
    @(negedge clk);
    #1;
    checks++; if (flags !== 6'b000000) begin errors++; $display("FAIL reset_flags got %b exp 000000", flags); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({s_vec, r_vec, grant_id, idx_err} !== 15'd0) begin errors++; $display("FAIL reset_outs got %b/%b/%0d/%b exp 0", s_vec, r_vec, grant_id, idx_err); end
    tick();
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_held got %b exp 0000", req_ready); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b exp 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
    checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL reset_first_drive got busy=%b id=%0d exp busy=1 id=0", busy, grant_id); end
    tick();
  endtask

  task automatic test_single_set();
    do_reset();
    set_req(1, 1'b1, 2'b10, 3'd2);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready got %b exp 0010", req_ready); end
    tick();
    set_req(1, 1'b0, 2'b10, 3'd2);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_drive got %b exp 0000", req_ready); end
    checks++; if (s_vec !== 6'b000100 || r_vec !== 6'b000000) begin errors++; $display("FAIL single_pulse got s=%b r=%b exp s=000100 r=000000", s_vec, r_vec); end
    checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL single_grant got busy=%b id=%0d exp 1/1", busy, grant_id); end
    checks++; if (flags !== 6'b000000) begin errors++; $display("FAIL single_flags_early got %b exp 000000", flags); end
    tick();
    #1;
    checks++; if (flags !== 6'b000100) begin errors++; $display("FAIL single_flags got %b exp 000100", flags); end
    checks++; if (busy !== 1'b0 || s_vec !== 6'b000000) begin errors++; $display("FAIL single_idle got busy=%b s=%b exp 0/000000", busy, s_vec); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'b10, 3'(i));
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (req_ready !== (4'b0001 << k)) begin errors++; $display("FAIL rr_ready_%0d got %b exp %b", k, req_ready, 4'b0001 << k); end
      tick();
      set_req(k, 1'b0, 2'b10, 3'(k));
      #1;
      checks++; if (grant_id !== 2'(k) || s_vec !== (6'b000001 << k)) begin errors++; $display("FAIL rr_drive_%0d got id=%0d s=%b", k, grant_id, s_vec); end
      tick();
      #1;
    end
    checks++; if (flags !== 6'b001111) begin errors++; $display("FAIL rr_flags got %b exp 001111", flags); end
  endtask

  task automatic test_toggle_twice();
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      set_req(2, 1'b1, 2'b11, 3'd5);
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL tgl_ready_%0d got %b exp 0100", pass, req_ready); end
      tick();
      set_req(2, 1'b0, 2'b11, 3'd5);
      #1;
      checks++; if ((s_vec & r_vec) !== 6'b000000) begin errors++; $display("FAIL tgl_overlap_%0d got s=%b r=%b", pass, s_vec, r_vec); end
      checks++;
      if (pass == 0 ? (s_vec !== 6'b100000 || r_vec !== 6'b000000) : (r_vec !== 6'b100000 || s_vec !== 6'b000000)) begin
        errors++; $display("FAIL tgl_pulse_%0d got s=%b r=%b", pass, s_vec, r_vec);
      end
      tick();
      #1;
      checks++; if (flags !== (pass == 0 ? 6'b100000 : 6'b000000)) begin errors++; $display("FAIL tgl_flags_%0d got %b", pass, flags); end
      checks++; if ((s_vec & r_vec) !== 6'b000000) begin errors++; $display("FAIL tgl_overlap_idle_%0d got s=%b r=%b", pass, s_vec, r_vec); end
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    set_req(3, 1'b1, 2'b10, 3'd7);
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL oor_ready got %b exp 1000", req_ready); end
    tick();
    set_req(3, 1'b0, 2'b10, 3'd7);
    #1;
    checks++; if (idx_err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL oor_err got err=%b busy=%b exp 1/1", idx_err, busy); end
    checks++; if ((s_vec | r_vec) !== 6'b000000) begin errors++; $display("FAIL oor_pulse got s=%b r=%b exp 0", s_vec, r_vec); end
    tick();
    #1;
    checks++; if (idx_err !== 1'b0 || flags !== 6'b000000) begin errors++; $display("FAIL oor_after got err=%b flags=%b exp 0/000000", idx_err, flags); end
    set_req(0, 1'b1, 2'b10, 3'd0);
    set_req(3, 1'b1, 2'b10, 3'd0);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL oor_ptr_wrap got %b exp 0001", req_ready); end
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(1, 1'b1, 2'b10, 3'd1);
    #1;
    tick();
    set_req(1, 1'b0, 2'b10, 3'd1);
    #1;
    checks++; if (busy !== 1'b1 || s_vec !== 6'b000010) begin errors++; $display("FAIL mid_drive got busy=%b s=%b exp 1/000010", busy, s_vec); end
    rst = 1'b1;
    model_reset();
    set_req(2, 1'b1, 2'b10, 3'd2);
    #1;
    checks++; if (busy !== 1'b0 || s_vec !== 6'b000000 || r_vec !== 6'b000000) begin errors++; $display("FAIL mid_async got busy=%b s=%b r=%b exp 0", busy, s_vec, r_vec); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready got %b exp 0000", req_ready); end
    tick();
    #1;
    checks++; if (flags !== 6'b000000 || busy !== 1'b0) begin errors++; $display("FAIL mid_flags got %b busy=%b exp 000000/0", flags, busy); end
    rst = 1'b0;
    req_valid = 4'b0000;
    set_req(0, 1'b1, 2'b10, 3'd0);
    set_req(3, 1'b1, 2'b10, 3'd0);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr got %b exp 0001", req_ready); end
    req_valid = 4'b0000;
  endtask

  task automatic test_random();
    logic [3:0] exp_ready;
    logic [5:0] exp_s, exp_r;
    logic       exp_e;
    int         w;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && just_gr[i]) begin
          if ($urandom_range(1, 0) == 1) set_req(i, 1'b1, 2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)));
          else req_valid[i] = 1'b0;
        end else if (req_valid[i]) begin
          if ($urandom_range(9, 0) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
          set_req(i, 1'b1, 2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)));
        end
      end
      #1;
      exp_ready = 4'b0000; exp_s = 6'b000000; exp_r = 6'b000000; exp_e = 1'b0;
      if (m_drive) begin
        if (m_idx >= 6) exp_e = 1'b1;
        else if (m_op == 2) exp_s[m_idx] = 1'b1;
        else if (m_op == 1) exp_r[m_idx] = 1'b1;
        else if (m_op == 3) begin
          if (m_flags[m_idx]) exp_r[m_idx] = 1'b1;
          else exp_s[m_idx] = 1'b1;
        end
      end else begin
        w = -1;
        for (int k = 0; k < 4; k++) if (req_valid[(m_ptr + k) % 4] && w < 0) w = (m_ptr + k) % 4;
        if (w >= 0) exp_ready = 4'b0001 << w;
      end
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, req_ready, exp_ready); end
      checks++; if (flags !== m_flags) begin errors++; $display("FAIL rnd_flags cyc %0d got %b exp %b", cyc, flags, m_flags); end
      checks++; if (busy !== m_drive) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", cyc, busy, m_drive); end
      checks++; if (s_vec !== exp_s || r_vec !== exp_r) begin errors++; $display("FAIL rnd_pulse cyc %0d got s=%b r=%b exp s=%b r=%b", cyc, s_vec, r_vec, exp_s, exp_r); end
      checks++; if (idx_err !== exp_e) begin errors++; $display("FAIL rnd_idx_err cyc %0d got %b exp %b", cyc, idx_err, exp_e); end
      if (m_drive) begin
        checks++; if (grant_id !== 2'(m_gid)) begin errors++; $display("FAIL rnd_grant cyc %0d got %0d exp %0d", cyc, grant_id, m_gid); end
      end
      tick();
    end
    req_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_round_robin();
    test_toggle_twice();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
